// File: rtl/seg_codes_pkg.sv
// Shared digit-code definitions for the 7-segment formatter and decoders.
// Codes 0-9 are decimal digits; the rest are display glyphs.
package seg_codes_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CODE_MINUS   = 4'hA;
  localparam logic [DIGIT_W-1:0] CODE_LOWER_O = 4'hB;
  localparam logic [DIGIT_W-1:0] CODE_BLANK   = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } fmt_state_t;

  // Decimal digits needed to hold the magnitude of a DATA_W-bit signed value
  function automatic int bcd_digits(input int w);
    return (w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/seg_code_formatter_if.sv
// Request/result bundle between the command logic and the code formatter.
// Master issues start/value; slave returns busy/valid/overflow/codes.
interface seg_code_formatter_if
  import seg_codes_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 6
);

  logic                        start;
  logic [DATA_W-1:0]           value;
  logic                        busy;
  logic                        valid;
  logic                        overflow;
  logic [DIGITS*DIGIT_W-1:0]   codes;

  modport master (
    output start,
    output value,
    input  busy,
    input  valid,
    input  overflow,
    input  codes
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output valid,
    output overflow,
    output codes
  );

endinterface

// File: rtl/seg_code_formatter_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is >= 5.
// Purely combinational.
module bcd_add3
  import seg_codes_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5)
      q = d + 4'd3;
  end

endmodule

// File: rtl/seg_code_formatter.sv
// Signed binary to per-digit display codes via bit-serial double-dabble,
// with leading-zero blanking, sign placement and overflow marking.
module seg_code_formatter
  import seg_codes_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 6
)
(
  input logic                clk,
  input logic                rst_n,
  seg_code_formatter_if.slave bus
);

  localparam int BCD_D = bcd_digits(DATA_W);
  localparam int BW    = BCD_D * DIGIT_W;
  localparam int OW    = DIGITS * DIGIT_W;
  localparam int PW    = (DIGITS + BCD_D) * DIGIT_W;
  localparam int CW    = $clog2(DATA_W + 1);

  fmt_state_t         state;
  logic               sign;
  logic [DATA_W-1:0]  mag;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      adj;
  logic [CW-1:0]      cnt;

  logic               busy_q;
  logic               valid_q;
  logic               ovf_q;
  logic [OW-1:0]      codes_q;

  logic [PW-1:0]      pad;
  int                 n_dig;
  logic               fmt_ovf;
  logic [OW-1:0]      fmt_codes;

  for (genvar g = 0; g < BCD_D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd[g*DIGIT_W +: DIGIT_W]),
      .q (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Zero-extend so digit positions beyond the BCD width read as zero
  assign pad = PW'(bcd);

  always_comb begin
    n_dig = 1;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] != '0)
        n_dig = i + 1;
    end
    fmt_ovf   = (n_dig + int'(sign)) > DIGITS;
    fmt_codes = {DIGITS{CODE_BLANK}};
    for (int d = 0; d < DIGITS; d++) begin
      if (fmt_ovf)
        fmt_codes[d*DIGIT_W +: DIGIT_W] = CODE_MINUS;
      else if (d < n_dig)
        fmt_codes[d*DIGIT_W +: DIGIT_W] = pad[d*DIGIT_W +: DIGIT_W];
      else if (d == n_dig && sign)
        fmt_codes[d*DIGIT_W +: DIGIT_W] = CODE_MINUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sign    <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      codes_q <= {DIGITS{CODE_BLANK}};
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sign   <= bus.value[DATA_W-1];
            // Most negative value wraps to 2^(DATA_W-1) unsigned
            mag    <= bus.value[DATA_W-1] ?
                      (~bus.value + DATA_W'(1)) : bus.value;
            bcd    <= '0;
            cnt    <= CW'(DATA_W);
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {adj[BW-2:0], mag[DATA_W-1]};
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FORMAT;
        end
        FORMAT: begin
          codes_q <= fmt_codes;
          ovf_q   <= fmt_ovf;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.codes    = codes_q;

endmodule

// File: tb/tb_seg_code_formatter.sv
// Bench for seg_code_formatter: 6-digit and 4-digit builds side by side,
// checked against a decimal-arithmetic display model.
module tb_seg_code_formatter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg_code_formatter_if #(.DATA_W(16), .DIGITS(6)) b6 ();
  seg_code_formatter_if #(.DATA_W(16), .DIGITS(4)) b4 ();

  seg_code_formatter #(.DATA_W(16), .DIGITS(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  seg_code_formatter #(.DATA_W(16), .DIGITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Display model: decimal digits of |v|, minus after them, blanks beyond
  function automatic logic [31:0] model(input int v, input int nd,
                                        output logic ovf);
    int m, t, n;
    logic [3:0] ds [10];
    logic [31:0] c;
    m = (v < 0) ? -v : v;
    t = m;
    n = 0;
    do begin
      ds[n] = 4'(t % 10);
      t = t / 10;
      n++;
    end while (t > 0);
    ovf = (n + ((v < 0) ? 1 : 0)) > nd;
    c = 32'hCCCC_CCCC;
    for (int i = 0; i < 8; i++) begin
      if (i >= nd)            c[i*4 +: 4] = 4'h0;
      else if (ovf)           c[i*4 +: 4] = 4'hA;
      else if (i < n)         c[i*4 +: 4] = ds[i];
      else if (i == n && v < 0) c[i*4 +: 4] = 4'hA;
    end
    return c;
  endfunction

  task automatic launch(input int which, input int v);
    if (which == 6) begin
      b6.start = 1'b1;
      b6.value = 16'(v);
    end else begin
      b4.start = 1'b1;
      b4.value = 16'(v);
    end
    @(posedge clk);
    #1;
    b6.start = 1'b0;
    b4.start = 1'b0;
    b6.value = 16'($urandom);
    b4.value = 16'($urandom);
  endtask

  task automatic wait_done(input int which, output int lat, output int busyc,
                           output logic [31:0] c, output logic ovf);
    logic vl, bz;
    bz = (which == 6) ? b6.busy : b4.busy;
    busyc = bz ? 1 : 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      vl = (which == 6) ? b6.valid : b4.valid;
      bz = (which == 6) ? b6.busy : b4.busy;
      if (vl) break;
      if (bz) busyc++;
    end
    c   = (which == 6) ? {8'h0, b6.codes} : {16'h0, b4.codes};
    ovf = (which == 6) ? b6.overflow : b4.overflow;
  endtask

  task automatic conv(input int which, input int v, input string tag);
    int lat, busyc;
    logic [31:0] c, ec;
    logic ovf, eovf;
    @(negedge clk);
    launch(which, v);
    wait_done(which, lat, busyc, c, ovf);
    ec = model(v, which, eovf);
    chk($sformatf("%s latency", tag), lat, 17);
    chk($sformatf("%s busy_cycles", tag), busyc, 17);
    chk($sformatf("%s codes", tag), c, ec);
    chk($sformatf("%s overflow", tag), ovf, eovf);
    @(posedge clk);
    #1;
    chk($sformatf("%s valid_pulse", tag),
        (which == 6) ? b6.valid : b4.valid, 1'b0);
  endtask

  initial begin
    int lat, busyc, npulse, v;
    logic [31:0] c, ec;
    logic ovf, eovf;

    rst_n = 1'b0;
    b6.start = 1'b0;
    b6.value = '0;
    b4.start = 1'b0;
    b4.value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst codes6", b6.codes, 24'hCCCCCC);
    chk("rst codes4", b4.codes, 16'hCCCC);
    chk("rst busy", {b6.busy, b4.busy}, 2'b00);
    chk("rst valid", {b6.valid, b4.valid}, 2'b00);
    chk("rst ovf", {b6.overflow, b4.overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    conv(6, 0, "zero");
    conv(6, 1234, "p1234");
    conv(6, -7, "m7");
    conv(6, -32768, "min");
    conv(6, 32767, "max");

    // Second start mid-conversion must be dropped
    @(negedge clk);
    launch(6, 4321);
    repeat (4) @(posedge clk);
    #1;
    b6.start = 1'b1;
    b6.value = 16'(999);
    @(posedge clk);
    #1;
    b6.start = 1'b0;
    npulse = 0;
    c = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (b6.valid) begin
        npulse++;
        c = {8'h0, b6.codes};
      end
    end
    ec = model(4321, 6, eovf);
    chk("ignore pulses", npulse, 1);
    chk("ignore codes", c, ec);

    // Start accepted on the valid cycle
    @(negedge clk);
    launch(6, 555);
    wait_done(6, lat, busyc, c, ovf);
    chk("b2b first", c, model(555, 6, eovf));
    launch(6, -4096);
    wait_done(6, lat, busyc, c, ovf);
    ec = model(-4096, 6, eovf);
    chk("b2b latency", lat, 17);
    chk("b2b codes", c, ec);

    // Reset mid-conversion
    @(negedge clk);
    launch(6, 1234);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst codes", b6.codes, 24'hCCCCCC);
    chk("midrst busy", b6.busy, 1'b0);
    chk("midrst valid", b6.valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (b6.valid) npulse++;
    end
    chk("midrst no_valid", npulse, 0);

    conv(4, -999, "d4 m999");
    conv(4, -1000, "d4 m1000");
    conv(4, 12345, "d4 p12345");
    conv(4, 0, "d4 zero");

    for (int i = 0; i < 12; i++) begin
      v = int'($signed(16'($urandom)));
      conv(6, v, $sformatf("rnd6 %0d", v));
    end
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 24000)) - 12000;
      conv(4, v, $sformatf("rnd4 %0d", v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
